wb_write_scheduler: RTL

//  Writeback scheduler in front of the dual-write-port register file. Accepts results from the

---
 rtl/wb_write_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/wb_write_scheduler.sv
// Writeback scheduler: buffers Branch/ALU and Memory lane results in small per-lane FIFOs and
// drives the two register-file write ports, resolving same-rd collisions by instruction age (PC).
module wb_write_scheduler #(
    parameter int WIDTH = 32,
    parameter int RS    = 5,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [RS-1:0]    br_rd,
    input  logic [WIDTH-1:0] br_data,
    input  logic [WIDTH-1:0] br_pc,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [RS-1:0]    mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    input  logic [WIDTH-1:0] mem_pc,
    output logic             write_en_Branch,
    output logic [RS-1:0]    rd_Branch,
    output logic [WIDTH-1:0] wd_Branch,
    output logic [WIDTH-1:0] PC_out_Branch,
    output logic             write_en_Memory,
    output logic [RS-1:0]    rd_Memory,
    output logic [WIDTH-1:0] wd_Memory,
    output logic [WIDTH-1:0] PC_out_Memory,
    output logic [CNT_W-1:0] commit_cnt,
    output logic [CNT_W-1:0] squash_cnt
);
    // Handshake: a lane transfer happens on a posedge where x_valid && x_ready; x_ready depends
    // only on the lane FIFO occupancy, and a producer seeing !x_ready keeps its payload stable.

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Lane index 0 is Branch/ALU, lane index 1 is Memory.
    logic [RS-1:0]    q_rd   [2][DEPTH];
    logic [WIDTH-1:0] q_data [2][DEPTH];
    logic [WIDTH-1:0] q_pc   [2][DEPTH];
    logic [AW-1:0]    wr_ptr [2];
    logic [AW-1:0]    rd_ptr [2];
    logic [AW:0]      count  [2];

    logic             in_valid [2];
    logic [RS-1:0]    in_rd    [2];
    logic [WIDTH-1:0] in_data  [2];
    logic [WIDTH-1:0] in_pc    [2];
    logic             full     [2];
    logic             push     [2];
    logic             pop      [2];
    logic [RS-1:0]    h_rd     [2];
    logic [WIDTH-1:0] h_data   [2];
    logic [WIDTH-1:0] h_pc     [2];

    logic issue_b, issue_m, conflict;
    logic [CNT_W:0] commit_sum, squash_sum;

    assign in_valid[0] = br_valid;
    assign in_rd[0]    = br_rd;
    assign in_data[0]  = br_data;
    assign in_pc[0]    = br_pc;
    assign in_valid[1] = mem_valid;
    assign in_rd[1]    = mem_rd;
    assign in_data[1]  = mem_data;
    assign in_pc[1]    = mem_pc;

    assign br_ready  = !full[0];
    assign mem_ready = !full[1];

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            full[l]   = (count[l] == FULL_CNT);
            // flush wins over a same-edge push and over any pop
            push[l]   = in_valid[l] && !full[l] && !flush;
            pop[l]    = (count[l] != '0) && !hold && !flush;
            h_rd[l]   = q_rd[l][rd_ptr[l]];
            h_data[l] = q_data[l][rd_ptr[l]];
            h_pc[l]   = q_pc[l][rd_ptr[l]];
        end
    end

    // rd==0 heads are popped without a write; same-rd heads keep only the younger (larger PC),
    // with ties going to the Memory lane.
    always_comb begin
        issue_b  = pop[0] && (h_rd[0] != '0);
        issue_m  = pop[1] && (h_rd[1] != '0);
        conflict = issue_b && issue_m && (h_rd[0] == h_rd[1]);
        if (conflict) begin
            if (h_pc[0] > h_pc[1]) issue_m = 1'b0;
            else                   issue_b = 1'b0;
        end
        commit_sum = {1'b0, commit_cnt} + (CNT_W+1)'(issue_b) + (CNT_W+1)'(issue_m);
        squash_sum = {1'b0, squash_cnt} + (CNT_W+1)'(conflict);
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (push[l]) begin
                q_rd[l][wr_ptr[l]]   <= in_rd[l];
                q_data[l][wr_ptr[l]] <= in_data[l];
                q_pc[l][wr_ptr[l]]   <= in_pc[l];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < 2; l++) begin
                wr_ptr[l] <= '0;
                rd_ptr[l] <= '0;
                count[l]  <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (flush) begin
                    wr_ptr[l] <= '0;
                    rd_ptr[l] <= '0;
                    count[l]  <= '0;
                end else begin
                    if (push[l]) wr_ptr[l] <= wr_ptr[l] + 1'b1;
                    if (pop[l])  rd_ptr[l] <= rd_ptr[l] + 1'b1;
                    if (push[l] && !pop[l])      count[l] <= count[l] + 1'b1;
                    else if (!push[l] && pop[l]) count[l] <= count[l] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_en_Branch <= 1'b0;
            rd_Branch       <= '0;
            wd_Branch       <= '0;
            PC_out_Branch   <= '0;
            write_en_Memory <= 1'b0;
            rd_Memory       <= '0;
            wd_Memory       <= '0;
            PC_out_Memory   <= '0;
            commit_cnt      <= '0;
            squash_cnt      <= '0;
        end else begin
            write_en_Branch <= issue_b;
            write_en_Memory <= issue_m;
            if (issue_b) begin
                rd_Branch     <= h_rd[0];
                wd_Branch     <= h_data[0];
                PC_out_Branch <= h_pc[0];
            end
            if (issue_m) begin
                rd_Memory     <= h_rd[1];
                wd_Memory     <= h_data[1];
                PC_out_Memory <= h_pc[1];
            end
            // counters stick at all-ones once the carry bit is set
            commit_cnt <= commit_sum[CNT_W] ? '1 : commit_sum[CNT_W-1:0];
            squash_cnt <= squash_sum[CNT_W] ? '1 : squash_sum[CNT_W-1:0];
        end
    end

endmodule
